// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: DW bits split into NSTG registered carry segments.
// Optional signed-overflow output is built only when CLA_OVF_EN is defined.

module ClaSegment #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int NG = W / 4;

   logic [W-1:0]  g;
   logic [W-1:0]  p;
   logic [NG-1:0] grpG;
   logic [NG-1:0] grpP;
   logic [NG:0]   grpC;
   logic [W-1:0]  bitC;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      grpG = '0;
      grpP = '0;
      for (int j = 0; j < NG; j++) begin
         grpP[j] = &p[4*j +: 4];
         grpG[j] = g[4*j+3]
                 | (p[4*j+3] & g[4*j+2])
                 | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                 | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
   end

   // Each group carry is a flat sum of generate/propagate products back to cin.
   always_comb begin : groupLookahead
      logic prod;
      logic acc;
      grpC    = '0;
      grpC[0] = cin;
      for (int j = 0; j < NG; j++) begin
         prod = 1'b1;
         acc  = grpG[j];
         for (int i = j - 1; i >= 0; i--) begin
            prod = prod & grpP[i+1];
            acc  = acc | (grpG[i] & prod);
         end
         prod      = prod & grpP[0];
         acc       = acc | (cin & prod);
         grpC[j+1] = acc;
      end
   end

   always_comb begin : bitCarries
      logic cur;
      bitC = '0;
      for (int j = 0; j < NG; j++) begin
         cur = grpC[j];
         for (int n = 0; n < 4; n++) begin
            bitC[4*j+n] = cur;
            cur         = g[4*j+n] | (p[4*j+n] & cur);
         end
      end
   end

   assign sum  = p ^ bitC;
   assign cout = grpC[NG];

endmodule

module cla_pipe #(
   parameter int DW   = 32,
   parameter int NSTG = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic          i_vld,
   input  logic          i_sub,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic          i_c,
   output logic          o_vld,
   output logic [DW-1:0] o_s,
   output logic          o_c,
   output logic          o_ovf
);

   localparam int SEG = DW / NSTG;

   logic [DW-1:0] bEff;
   logic          cinEff;

   assign bEff   = i_b ^ {DW{i_sub}};
   assign cinEff = i_c ^ i_sub;

   for (genvar k = 0; k < NSTG; k++) begin : gStg
      localparam int REM = DW - (k + 1) * SEG;

      logic [SEG-1:0]         segA;
      logic [SEG-1:0]         segB;
      logic [SEG-1:0]         segSum;
      logic                   segCin;
      logic                   segCout;
      logic                   vldIn;
      logic [(k+1)*SEG-1:0]   sum_d;
      logic [(k+1)*SEG-1:0]   sum_q;
      logic                   carry_q;
      logic                   vld_q;

      // Stage k takes its operand slice from the skew chain and its carry from stage k-1.
      if (k == 0) begin : gHead
         assign segA   = i_a[SEG-1:0];
         assign segB   = bEff[SEG-1:0];
         assign segCin = cinEff;
         assign vldIn  = i_vld;
         assign sum_d  = segSum;
      end else begin : gTail
         assign segA   = gStg[k-1].gOps.opA_q[SEG-1:0];
         assign segB   = gStg[k-1].gOps.opB_q[SEG-1:0];
         assign segCin = gStg[k-1].carry_q;
         assign vldIn  = gStg[k-1].vld_q;
         assign sum_d  = {segSum, gStg[k-1].sum_q};
      end

      ClaSegment #(.W(SEG)) uAdd (
         .a    (segA),
         .b    (segB),
         .cin  (segCin),
         .sum  (segSum),
         .cout (segCout)
      );

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            vld_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
         end else if (i_en) begin
            vld_q <= vldIn;
            if (vldIn) begin
               carry_q <= segCout;
               sum_q   <= sum_d;
            end
         end
      end

      if (REM > 0) begin : gOps
         logic [REM-1:0] opA_d;
         logic [REM-1:0] opB_d;
         logic [REM-1:0] opA_q;
         logic [REM-1:0] opB_q;

         if (k == 0) begin : gSrcIn
            assign opA_d = i_a[DW-1:SEG];
            assign opB_d = bEff[DW-1:SEG];
         end else begin : gSrcPrev
            assign opA_d = gStg[k-1].gOps.opA_q[REM+SEG-1:SEG];
            assign opB_d = gStg[k-1].gOps.opB_q[REM+SEG-1:SEG];
         end

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               opA_q <= '0;
               opB_q <= '0;
            end else if (i_en && vldIn) begin
               opA_q <= opA_d;
               opB_q <= opB_d;
            end
         end
      end
   end

   assign o_vld = gStg[NSTG-1].vld_q;
   assign o_s   = gStg[NSTG-1].sum_q;
   assign o_c   = gStg[NSTG-1].carry_q;

`ifdef CLA_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Carry into the MSB is recovered from the MSB's operand and sum bits.
   assign ovf_d = gStg[NSTG-1].segA[SEG-1] ^ gStg[NSTG-1].segB[SEG-1]
                ^ gStg[NSTG-1].segSum[SEG-1] ^ gStg[NSTG-1].segCout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_q <= 1'b0;
      end else if (i_en && gStg[NSTG-1].vldIn) begin
         ovf_q <= ovf_d;
      end
   end

   assign o_ovf = ovf_q;
`else
   assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// Directed bench for cla_pipe: reset, carry chains, subtract, overflow, stall and streaming
// across NSTG = 4, 1 and 8.

module tb_cla_pipe;

`ifdef CLA_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, en, vld, sub, cin;
   logic [31:0] a, b;

   logic        vld4, c4, ovf4;
   logic [31:0] s4;
   logic        vld1, c1, ovf1;
   logic [31:0] s1;
   logic        vld8, c8, ovf8;
   logic [31:0] s8;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] va [20];
   logic [31:0] vb [20];
   logic        vc [20];
   logic        vs [20];
   logic [32:0] vr [20];
   logic        vo [20];
   logic [31:0] beff;

   always #5 clk = ~clk;

   cla_pipe #(.DW(32), .NSTG(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_sub(sub),
      .i_a(a), .i_b(b), .i_c(cin),
      .o_vld(vld4), .o_s(s4), .o_c(c4), .o_ovf(ovf4)
   );

   cla_pipe #(.DW(32), .NSTG(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_sub(sub),
      .i_a(a), .i_b(b), .i_c(cin),
      .o_vld(vld1), .o_s(s1), .o_c(c1), .o_ovf(ovf1)
   );

   cla_pipe #(.DW(32), .NSTG(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_sub(sub),
      .i_a(a), .i_b(b), .i_c(cin),
      .o_vld(vld8), .o_s(s8), .o_c(c8), .o_ovf(ovf8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic sb, input logic [31:0] aa,
                                input logic [31:0] bb, input logic cc);
      vld = v;
      sub = sb;
      a   = aa;
      b   = bb;
      cin = cc;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated operation through the NSTG=4 pipe, with latency, value and hold checks.
   task automatic runOne(input string tag, input logic sb, input logic [31:0] aa,
                         input logic [31:0] bb, input logic cc, input logic [31:0] expS,
                         input logic expC, input logic expOvf);
      applyStimulus(1'b1, sb, aa, bb, cc);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput({tag, "_early"}, 64'(vld4), 64'(1'b0));
      tick();
      checkOutput({tag, "_vld"}, 64'(vld4), 64'(1'b1));
      checkOutput({tag, "_s"}, 64'(s4), 64'(expS));
      checkOutput({tag, "_c"}, 64'(c4), 64'(expC));
      checkOutput({tag, "_ovf"}, 64'(ovf4), 64'(OVF_ON & expOvf));
      tick();
      checkOutput({tag, "_drain"}, 64'(vld4), 64'(1'b0));
      checkOutput({tag, "_hold"}, 64'(s4), 64'(expS));
   endtask

   task automatic checkStream(input string tag, input logic ov, input logic [31:0] os,
                              input logic oc, input logic oo, input int idx);
      if (idx >= 0 && idx < 20) begin
         checkOutput($sformatf("%s_vld%0d", tag, idx), 64'(ov), 64'(1'b1));
         checkOutput($sformatf("%s_sum%0d", tag, idx), 64'({oc, os}), 64'(vr[idx]));
         checkOutput($sformatf("%s_ovf%0d", tag, idx), 64'(oo), 64'(OVF_ON & vo[idx]));
      end else begin
         checkOutput($sformatf("%s_idle%0d", tag, idx), 64'(ov), 64'(1'b0));
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("rst_vld", 64'(vld4), 64'(1'b0));
      checkOutput("rst_s", 64'(s4), 64'h0);
      checkOutput("rst_c", 64'(c4), 64'h0);
      checkOutput("rst_ovf", 64'(ovf4), 64'h0);
      rst = 1'b0;
      tick();

      runOne("fullcarry", 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      runOne("segcarry", 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
      runOne("sub5m7", 1'b1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      runOne("sub7m5", 1'b1, 32'd7, 32'd5, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
      runOne("sub7m5m1", 1'b1, 32'd7, 32'd5, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
      runOne("ovfadd", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      runOne("ovfsub", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Stall with four ops in flight; junk offered during the stall must be ignored.
      applyStimulus(1'b1, 1'b0, 32'd1, 32'd2, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'd10, 32'd20, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      tick();
      checkOutput("stall_r0_vld", 64'(vld4), 64'(1'b1));
      checkOutput("stall_r0", 64'({c4, s4}), 64'(33'h0_0000_0003));
      en = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("stall_frz_vld%0d", i), 64'(vld4), 64'(1'b1));
         checkOutput($sformatf("stall_frz_s%0d", i), 64'({c4, s4}), 64'(33'h0_0000_0003));
      end
      en = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("stall_r1_vld", 64'(vld4), 64'(1'b1));
      checkOutput("stall_r1", 64'({c4, s4}), 64'(33'h0_0000_001E));
      tick();
      checkOutput("stall_r2_vld", 64'(vld4), 64'(1'b1));
      checkOutput("stall_r2", 64'({c4, s4}), 64'(33'h1_0000_0000));
      tick();
      checkOutput("stall_r3_vld", 64'(vld4), 64'(1'b1));
      checkOutput("stall_r3", 64'({c4, s4}), 64'(33'h0_2345_6789));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("stall_after%0d", i), 64'(vld4), 64'(1'b0));
      end

      // Reset mid-stream discards in-flight work.
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0400, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("midrst_vld", 64'(vld4), 64'(1'b0));
      checkOutput("midrst_s", 64'(s4), 64'h0);
      checkOutput("midrst_c", 64'(c4), 64'h0);
      checkOutput("midrst_ovf", 64'(ovf4), 64'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("midrst_stale%0d", i), 64'(vld4), 64'(1'b0));
      end

      // Streaming: 20 back-to-back ops checked on all three pipe depths.
      for (int i = 0; i < 20; i++) begin
         va[i] = $urandom;
         vb[i] = $urandom;
         vc[i] = 1'($urandom_range(0, 1));
         vs[i] = 1'($urandom_range(0, 1));
         beff  = vs[i] ? ~vb[i] : vb[i];
         vr[i] = {1'b0, va[i]} + {1'b0, beff} + {32'h0, vc[i] ^ vs[i]};
         vo[i] = (va[i][31] == beff[31]) && (vr[i][31] != va[i][31]);
      end
      for (int t = 0; t < 28; t++) begin
         if (t < 20) begin
            applyStimulus(1'b1, vs[t], va[t], vb[t], vc[t]);
         end else begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         end
         tick();
         checkStream("n4", vld4, s4, c4, ovf4, t - 3);
         checkStream("n1", vld1, s1, c1, ovf1, t);
         checkStream("n8", vld8, s8, c8, ovf8, t - 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised pipelined carry-lookahead adder/subtractor: next generation of the 32-bit combinational `cla`. It splits a DW-bit operation into NSTG registered segments, with carry passed between stages, to reach higher clock rates. It accepts one operation per cycle under a valid/enable handshake and sits in the datapath wherever a wide add/sub must close timing at 100 MHz and above.

## Interface
- DW, 32, operand/sum width; must be a multiple of 4*NSTG
- NSTG, 4, pipeline stages = carry segments; 1 ≤ NSTG ≤ DW/4
- One clock; reset is synchronous and active-high.
- i_clk  input  1  clock, all flops rising-edge
- i_rst  input  1  synchronous active-high reset
- i_en  input  1  pipeline advance; 0 = freeze every register
- i_vld  input  1  input operation valid
- i_sub  input  1  1 = subtract mode
- i_a  input  DW  operand A
- i_b  input  DW  operand B
- i_c  input  1  carry-in (borrow-in complement in subtract mode)
- o_vld  output  1  result valid
- o_s  output  DW  sum/difference
- o_c  output  1  carry-out of MSB
- o_ovf  output  1  signed overflow (see Configuration)

## Operation
- Effective operands: B' = i_b ^ {DW{i_sub}}, cin' = i_c ^ i_sub; result {o_c, o_s} = i_a + B' + cin' (mod 2^(DW+1)).
  - i_sub=1, i_c=0 → A−B; i_sub=1, i_c=1 → A−B−1; in subtract mode o_c=1 means no borrow.
- SEG = DW/NSTG. Stage k (0..NSTG−1) computes bits [k*SEG +: SEG] with 4-bit CLA groups and group-lookahead inside the segment, using the carry registered by stage k−1 (stage 0 uses cin').
- Skew registers delay the upper operand segments (segment k by k cycles). Deskew registers delay the lower sum segments so that all DW bits and o_c leave aligned.
- A valid bit travels with each stage. A stage's data registers load only when i_en=1 and the incoming valid=1. Output registers therefore hold the last valid result while o_vld=0.
- i_en=0: all data and valid registers hold; i_vld and operands are ignored that cycle. The upstream block must hold or replay.
- Reset: all valid bits 0; o_s=0, o_c=0, o_ovf=0; every skew/deskew/carry register cleared. In-flight operations are discarded, with no partial output.
- i_rst and i_en together: reset wins.

## Timing
- Latency: exactly NSTG enabled cycles from input sample (i_vld=1, i_en=1 at edge t) to o_vld=1 after the edge at t+NSTG−1. NSTG=1 gives a single registered stage.
- Throughput: 1 op/cycle with i_en held high. Back-to-back ops emerge in order with no bubbles inserted.
- Bubbles (i_vld=0) propagate as o_vld=0 at the same latency.
- The critical path is one SEG-bit CLA plus one carry flop, independent of DW.
- All outputs are registered; no combinational input→output path.

## Configuration
- CLA_OVF_EN defined: o_ovf = (carry into MSB) XOR (carry out of MSB) of the effective addition. It is registered and aligned with o_s/o_vld, holds with the data, and resets to 0.
- CLA_OVF_EN undefined: o_ovf is tied to 0 and no overflow logic or flops are built. The port list is unchanged.

## Test plan
All cases use DW=32, NSTG=4 unless noted.
- Reset: i_rst=1 for 2 cycles mid-stream, then release → o_vld=0, o_s=0, o_c=0, o_ovf=0 on the first cycle after reset; no stale results emerge afterwards.
- Full carry chain: A=0xFFFFFFFF, B=0, i_c=1 → 4 cycles later o_vld=1, o_s=0x00000000, o_c=1. Also A=0x0000FFFF, B=0x00000001 → o_s=0x00010000, o_c=0, exercising the cross-segment carry.
- Streaming: 20 random vectors with i_vld=1 on consecutive cycles → o_vld high for exactly 20 consecutive cycles starting at latency 4; each {o_c,o_s} equals A+B+C, in order. Repeat with NSTG=1 and NSTG=8.
- Subtract: A=5, B=7, i_sub=1, i_c=0 → o_s=0xFFFFFFFE, o_c=0. A=7, B=5 → o_s=0x00000002, o_c=1.
- Stall: i_en=0 for 3 cycles while 4 ops are in flight → o_vld/o_s frozen during the stall; after resume all 4 results arrive once each, unchanged.
- Overflow: A=0x7FFFFFFF, B=1, add → o_s=0x80000000, o_c=0. o_ovf=1 with CLA_OVF_EN defined; o_ovf=0 without it. A=0x80000000 minus B=1 → o_ovf=1 (macro defined).
